// File: rtl/ext_pkg.sv
// Shared types and default widths for the immediate/load-data extender.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ext_pkg;

  localparam int EXT_DATA_W = 32;
  localparam int EXT_IMM_W  = 16;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SIGN = 3'd1,
    HIGH = 3'd2,
    LB   = 3'd3,
    LBU  = 3'd4,
    LH   = 3'd5,
    LHU  = 3'd6,
    LW   = 3'd7
  } ext_mode_e;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/ext_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (main output register + one skid entry), with flush.
// Latency: 1 cycle; a payload accepted at edge N is presented from edge N.
// Backpressure: in_ready is a flop, low only while the skid entry holds data.
module ext_skid_buf
  import ext_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         rdy_q;
  logic         acc, drn;
  logic         main_ld, main_from_skid, skid_ld;

  assign acc       = in_valid && rdy_q;
  assign drn       = (state_q != BUF_EMPTY) && out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = main_q;

  // Next occupancy and which register loads; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (acc) begin
          state_d = BUF_ONE;
          main_ld = 1'b1;
        end
      end
      BUF_ONE: begin
        if (acc && drn) begin
          main_ld = 1'b1;
        end else if (acc) begin
          state_d = BUF_TWO;
          skid_ld = 1'b1;
        end else if (drn) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (drn) begin
          state_d        = BUF_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    if (flush) begin
      state_d        = BUF_EMPTY;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
    end
  end

  // Occupancy, registered ready and the two payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= BUF_EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != BUF_TWO);
      if (main_ld) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_ld) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// Immediate (zero/sign/high) and load-data (byte/half/word lane + extend) extender.
// Latency: 1 cycle through a 2-entry skid buffer, one result per cycle.
// Backpressure: in_ready (registered) drops once two results are held un-drained.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = EXT_DATA_W,
  parameter int IMM_W  = EXT_IMM_W,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  ext_mode_e         mode;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] res;
  logic              err;
  logic [DATA_W:0]   buf_out;

  assign mode = ext_mode_e'(in_mode);

  // Little-endian lane select: shift the addressed byte down to bit 0.
  assign byte_lane = 8'(in_data >> {in_off, 3'b000});
  assign half_lane = 16'(in_data >> {in_off, 3'b000});

  // Extend per mode; a misaligned load yields zero data with the error flag.
  always_comb begin
    res = '0;
    err = 1'b0;
    case (mode)
      ZERO: res = {{(DATA_W-IMM_W){1'b0}}, in_imm};
      SIGN: res = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
      HIGH: res = {in_imm, {(DATA_W-IMM_W){1'b0}}};
      LB:   res = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      LBU:  res = {{(DATA_W-8){1'b0}}, byte_lane};
      LH: begin
        if (in_off[0]) err = 1'b1;
        else           res = {{(DATA_W-16){half_lane[15]}}, half_lane};
      end
      LHU: begin
        if (in_off[0]) err = 1'b1;
        else           res = {{(DATA_W-16){1'b0}}, half_lane};
      end
      LW: begin
        if (in_off != '0) err = 1'b1;
        else              res = in_data;
      end
      default: res = '0;
    endcase
  end

  ext_skid_buf #(
    .W(DATA_W + 1)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({err, res}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_data = buf_out[DATA_W-1:0];
  assign out_err  = buf_out[DATA_W];

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe: 32-bit instance plus a 64-bit instance.
module tb_ext_pipe;
  import ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_mode = 3'd0;
  logic [15:0] in_imm = '0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_off = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_err;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [2:0]  in_mode64 = 3'd0;
  logic [15:0] in_imm64 = '0;
  logic [63:0] in_data64 = '0;
  logic [2:0]  in_off64 = '0;
  logic        out_valid64;
  logic [63:0] out_data64;
  logic        out_err64;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ext_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_imm(in_imm), .in_data(in_data), .in_off(in_off),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  ext_pipe #(.DATA_W(64), .IMM_W(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_mode(in_mode64),
    .in_imm(in_imm64), .in_data(in_data64), .in_off(in_off64),
    .out_valid(out_valid64), .out_ready(1'b1),
    .out_data(out_data64), .out_err(out_err64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request with out_ready high; result checked the cycle after accept.
  task automatic run32(input string tag, input ext_mode_e mode, input logic [15:0] imm,
                       input logic [31:0] data, input logic [1:0] off,
                       input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    in_valid = 1'b1; in_mode = mode; in_imm = imm; in_data = data; in_off = off;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_dat"}, 64'(out_data), 64'(exp_d));
    chk({tag, "_err"}, 64'(out_err), 64'(exp_e));
  endtask

  task automatic run64(input string tag, input ext_mode_e mode, input logic [63:0] data,
                       input logic [2:0] off, input logic [63:0] exp_d);
    @(negedge clk);
    in_valid64 = 1'b1; in_mode64 = mode; in_data64 = data; in_off64 = off;
    @(negedge clk);
    in_valid64 = 1'b0;
    chk({tag, "_vld"}, 64'(out_valid64), 64'd1);
    chk({tag, "_dat"}, out_data64, exp_d);
    chk({tag, "_err"}, 64'(out_err64), 64'd0);
  endtask

  logic [15:0] req [4];
  int sent, got;

  initial begin
    // Reset state
    #12;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_dat", 64'(out_data), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Immediates
    run32("sign", SIGN, 16'h8001, 32'hDEADBEEF, 2'd3, 32'hFFFF8001, 1'b0);
    run32("zero", ZERO, 16'h8001, 32'hDEADBEEF, 2'd1, 32'h00008001, 1'b0);
    run32("high", HIGH, 16'h1234, 32'h0, 2'd0, 32'h12340000, 1'b0);

    // Byte lanes
    run32("lb0",  LB,  16'hFFFF, 32'h80FF7F01, 2'd0, 32'h00000001, 1'b0);
    run32("lb1",  LB,  16'h0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0);
    run32("lb2",  LB,  16'h0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0);
    run32("lb3",  LB,  16'h0, 32'h80FF7F01, 2'd3, 32'hFFFFFF80, 1'b0);
    run32("lbu3", LBU, 16'h0, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0);

    // Halves and words, including misalignment
    run32("lh2",  LH,  16'h0, 32'h80001234, 2'd2, 32'hFFFF8000, 1'b0);
    run32("lhu2", LHU, 16'h0, 32'h80001234, 2'd2, 32'h00008000, 1'b0);
    run32("lh0",  LH,  16'h0, 32'h80001234, 2'd0, 32'h00001234, 1'b0);
    run32("lh1",  LH,  16'h0, 32'h80001234, 2'd1, 32'h00000000, 1'b1);
    run32("lw0",  LW,  16'h0, 32'hCAFEF00D, 2'd0, 32'hCAFEF00D, 1'b0);
    run32("lw2",  LW,  16'h0, 32'hCAFEF00D, 2'd2, 32'h00000000, 1'b1);

    // 64-bit instance
    run64("w64_lw0",  LW,  64'h0123456789ABCDEF, 3'd0, 64'h0123456789ABCDEF);
    run64("w64_lb7",  LB,  64'h8A00000000000055, 3'd7, 64'hFFFFFFFFFFFFFF8A);
    run64("w64_lbu7", LBU, 64'h8A00000000000055, 3'd7, 64'h000000000000008A);

    // Back-pressure: 4 back-to-back ZERO requests, out_ready low for 3 cycles
    for (int i = 0; i < 4; i++) req[i] = 16'h1111 * 16'(i + 1);
    sent = 0; got = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (sent < 4);
      in_mode   = ZERO;
      in_imm    = (sent < 4) ? req[sent] : 16'h0;
      if (cyc == 2) chk("bp_rdy_low", 64'(in_ready), 64'd0);
      if (cyc == 2) chk("bp_sent2", 64'(sent), 64'd2);
      if (cyc == 4) chk("bp_rdy_back", 64'(in_ready), 64'd1);
      if (out_valid && out_ready) begin
        if (got < 4) chk("bp_order", 64'(out_data), {48'h0, req[got]});
        else         chk("bp_extra", 64'(got), 64'd4);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(got), 64'd4);
    chk("bp_idle", 64'(out_valid), 64'd0);

    // Flush with two entries held and a request presented
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = ZERO; in_imm = 16'hA001;
    @(negedge clk);
    in_imm = 16'hA002;
    @(negedge clk);
    chk("fl_two_rdy", 64'(in_ready), 64'd0);
    in_imm = 16'hA003; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", 64'(out_valid), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);

    // Flush with one entry and a request that actually handshakes: dropped
    in_valid = 1'b1; in_imm = 16'hB001;
    @(negedge clk);
    in_imm = 16'hB002; flush = 1'b1;
    chk("fl1_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl1_vld", 64'(out_valid), 64'd0);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      chk("fl_ghost", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset with main=data, skid=error entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = LW; in_data = 32'h5A5A1234; in_off = 2'd0;
    @(negedge clk);
    in_mode = LH; in_off = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_pre_dat", 64'(out_data), 64'h5A5A1234);
    chk("ar_pre_rdy", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", 64'(out_valid), 64'd0);
    chk("ar_dat", 64'(out_data), 64'd0);
    chk("ar_err", 64'(out_err), 64'd0);
    chk("ar_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("ar_after", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined immediate/load-data extender for the pipelined MIPS datapath. It extends immediates (zero, sign, high-half) and load data (byte/half/word lane select plus sign/zero extend) in one block. The block sits between the ID/MEM operand sources and the next pipeline register, behind a valid/ready handshake with a 2-entry skid buffer. Latency is one cycle, throughput is one result per cycle, and it supports stall and flush.

## Interface
Parameters:
- DATA_W, 32 — result/load-word width; multiple of 16, at least 32
- IMM_W, 16 — immediate width; must be less than DATA_W
- OFF_W, $clog2(DATA_W/8) — byte-offset width (derived; do not override)

Ports:
- clk  in  1  — clock
- rst_n  in  1  — reset, asynchronous, active-low
- flush  in  1  — discard all buffered results at the next edge
- in_valid  in  1  — request present
- in_ready  out  1  — block can accept; registered
- in_mode  in  3  — operation select (ext_pkg::ext_mode_e)
- in_imm  in  IMM_W  — immediate operand
- in_data  in  DATA_W  — raw load word
- in_off  in  OFF_W  — byte offset of load within word
- out_valid  out  1  — result present
- out_ready  in  1  — consumer accepts
- out_data  out  DATA_W  — extended result
- out_err  out  1  — misaligned load flag, qualified by out_valid

## Operation
- Modes:
  - 0 ZERO: zero-extend in_imm.
  - 1 SIGN: sign-extend in_imm from bit IMM_W-1.
  - 2 HIGH: in_imm placed at the top of the word, i.e. in_imm << (DATA_W-IMM_W), low bits 0.
  - 3 LB / 4 LBU: byte in_data[8*off+7 : 8*off], sign/zero-extended.
  - 5 LH / 6 LHU: half in_data[8*off+15 : 8*off], sign/zero-extended.
  - 7 LW: in_data unchanged.
- Lane order is little-endian. in_imm is ignored in load modes; in_data/in_off are ignored in immediate modes.
- Misalignment:
  - LH/LHU with off[0]=1, or LW with off≠0, sets out_err=1 and out_data=0.
  - All other cases produce out_err=0.
- Transfer: input fires on in_valid&&in_ready; output fires on out_valid&&out_ready.
- Buffer: a main output register plus one skid entry.
  - Accepted result goes to main if main is empty or draining this cycle, else to skid.
  - When main drains and skid is full, skid moves to main.
  - Results leave strictly in acceptance order.
- in_ready is registered: 0 exactly when the skid entry is occupied.
- Flush:
  - Main and skid are cleared at the next edge, so out_valid=0 and in_ready=1 in the following cycle.
  - A request handshaked in the same cycle as flush is dropped.
  - An output handshake in the flush cycle still counts as delivered.
- States (buffer occupancy): EMPTY, ONE (main only), TWO (main+skid).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without drain.
  - ONE→EMPTY on drain without accept.
  - TWO→ONE on drain.
  - Any state→EMPTY on flush.
  - No transition for a simultaneous accept+drain in ONE.

## Timing
- Reset (asynchronous assert, synchronous-release usage): out_valid=0, out_data=0, out_err=0, in_ready=1; skid cleared.
- Latency: result accepted at edge N is on out_data with out_valid=1 from edge N until it drains.
- out_data/out_err are stable while out_valid=1 and out_ready=0.
- Throughput: one result/cycle with out_ready held high; no bubbles.
- Back-pressure: with out_ready=0, two results are absorbed, then in_ready=0 from the cycle after the second accept. in_ready returns to 1 the cycle after the first drain.
- Reset mid-operation discards all entries immediately, with no partial output.

## Structure
- Package ext_pkg holds:
  - ext_mode_e: ZERO, SIGN, HIGH, LB, LBU, LH, LHU, LW, with the 3-bit encodings above.
  - Default width constants EXT_DATA_W=32 and EXT_IMM_W=16.
- The extend/lane-select logic is purely combinational inside ext_pipe.
- Buffering lives in one sub-module, ext_skid_buf, a generic 2-entry valid/ready skid buffer with a payload width parameter and a flush input. It is instantiated with payload DATA_W+1 (data, err).

## Test plan
- SIGN imm=16'h8001 → out_data=32'hFFFF8001. ZERO same imm → 32'h00008001. HIGH imm=16'h1234 → 32'h12340000. Each arrives one cycle after accept with out_err=0.
- Byte lanes, data=32'h80FF7F01:
  - LB off=0,1,2,3 → 32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80.
  - LBU off=3 → 32'h00000080.
- Halves: LH off=2 data=32'h8000_1234 → 32'hFFFF8000. LHU off=2 → 32'h00008000. LH off=1 → out_err=1, out_data=0. LW off=2 → out_err=1.
- Back-pressure: 4 back-to-back requests, out_ready=0 for 3 cycles → in_ready falls after 2 accepts. Releasing out_ready delivers all 4 results in order, with no loss or duplication.
- Flush with TWO entries plus a concurrent in_valid → next cycle out_valid=0 and in_ready=1; the concurrent request never appears.
- Assert rst_n=0 mid-stream, asynchronously between edges → out_valid, out_data and out_err go to 0 and in_ready to 1 immediately. DATA_W=64 instance: LW off=0 passes 64 bits unchanged, and LB off=7 selects bits [63:56].
